// File: rtl/stim_sequencer.sv
// -----------------------------------------------------------------------------
// stim_sequencer
//
// Purpose:
//   Table-driven stimulus sequencer. A host writes a table of {value, hold}
//   steps. On start the sequencer pulses the DUT reset low, then drives each
//   value on the switch bus for its hold count. It runs once or loops forever.
//
// Optional feature macro: STIM_CHECK_EN
//   When defined, each entry also stores an expected DUT response. dut_resp is
//   compared in the final hold cycle of every step. Mismatches are reported as
//   a one-cycle pulse and counted in a saturating 8-bit counter.
//   When undefined, mismatch and err_count are tied to zero.
//
// Ports:
//   CLOCK_50    in   system clock, rising edge
//   Reset       in   asynchronous active-high reset
//   wr_en       in   table write strobe (honoured only while not busy)
//   wr_addr     in   table entry index
//   wr_value    in   stimulus value for the entry
//   wr_hold     in   hold count for the entry (0 plays as 1)
//   wr_expect   in   expected DUT response for the entry
//   num_steps   in   active entry count, sampled at start (clamped to DEPTH)
//   loop        in   repeat sequence forever, sampled at start
//   start       in   begin a sequence from IDLE or DONE
//   dut_resp    in   DUT response to check
//   stim        out  stimulus bus
//   dut_resetn  out  active-low DUT reset
//   step_idx    out  current table entry
//   busy        out  sequencer is in RST or RUN
//   done        out  sequencer is in DONE
//   mismatch    out  one-cycle check-failure pulse
//   err_count   out  saturating mismatch count
// -----------------------------------------------------------------------------
module stim_sequencer #(
  parameter int W          = 10,
  parameter int DEPTH      = 8,
  parameter int CW         = 16,
  parameter int RST_CYCLES = 1
) (
  input  logic                       CLOCK_50,
  input  logic                       Reset,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [W-1:0]               wr_value,
  input  logic [CW-1:0]              wr_hold,
  input  logic [W-1:0]               wr_expect,
  input  logic [$clog2(DEPTH):0]     num_steps,
  input  logic                       loop,
  input  logic                       start,
  input  logic [W-1:0]               dut_resp,
  output logic [W-1:0]               stim,
  output logic                       dut_resetn,
  output logic [$clog2(DEPTH)-1:0]   step_idx,
  output logic                       busy,
  output logic                       done,
  output logic                       mismatch,
  output logic [7:0]                 err_count
);

  localparam int AW  = $clog2(DEPTH);
  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RST,
    S_RUN,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_stim;
  logic            r_rstn;
  logic [AW-1:0]   r_stepIdx;
  logic            r_busy;
  logic            r_done;
  logic [CW-1:0]   r_holdCnt;
  logic [RCW-1:0]  r_rstCnt;
  logic [AW:0]     r_numSteps;
  logic            r_loop;

  logic [W-1:0]    r_valueMem [DEPTH];
  logic [CW-1:0]   r_holdMem  [DEPTH];

  state_t          w_nextState;
  logic [W-1:0]    w_nextStim;
  logic            w_nextRstn;
  logic [AW-1:0]   w_nextIdx;
  logic [CW-1:0]   w_nextHold;
  logic [RCW-1:0]  w_nextRstCnt;
  logic [AW:0]     w_nextNum;
  logic            w_nextLoop;
  logic            w_clearErr;
  logic            w_stepEnd;

  logic            w_isLast;
  logic [AW-1:0]   w_wrapIdx;
  logic [AW-1:0]   w_loadIdx;
  logic [W-1:0]    w_loadValue;
  logic [CW-1:0]   w_loadHold;
  logic [AW:0]     w_clampSteps;
  logic            w_tableWrite;

  // Writes are locked out while a sequence is playing so the running table
  // cannot change underneath it. A write on the start edge still lands,
  // because busy only rises after that edge.
  assign w_tableWrite = wr_en && !r_busy;

  // The step that will be loaded next: entry 0 when leaving RST, otherwise the
  // following entry, wrapping to 0 after the last active step.
  assign w_isLast    = ({1'b0, r_stepIdx} == (r_numSteps - 1'b1));
  assign w_wrapIdx   = w_isLast ? '0 : r_stepIdx + 1'b1;
  assign w_loadIdx   = (r_state == S_RUN) ? w_wrapIdx : '0;
  assign w_loadValue = r_valueMem[w_loadIdx];
  assign w_loadHold  = (r_holdMem[w_loadIdx] == '0) ? CW'(1) : r_holdMem[w_loadIdx];

  assign w_clampSteps = (num_steps > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_steps;

  // Table storage. Deliberately not reset so a programmed pattern survives a
  // Reset and can be replayed.
  always_ff @(posedge CLOCK_50) begin
    if (w_tableWrite) begin
      r_valueMem[wr_addr] <= wr_value;
      r_holdMem[wr_addr]  <= wr_hold;
    end
  end

  // Next-state and next-output logic. Every output is computed here and
  // registered below, so the bus never glitches on a state change.
  always_comb begin
    w_nextState  = r_state;
    w_nextStim   = r_stim;
    w_nextRstn   = r_rstn;
    w_nextIdx    = r_stepIdx;
    w_nextHold   = r_holdCnt;
    w_nextRstCnt = r_rstCnt;
    w_nextNum    = r_numSteps;
    w_nextLoop   = r_loop;
    w_clearErr   = 1'b0;
    w_stepEnd    = 1'b0;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_nextState  = S_RST;
          w_nextNum    = w_clampSteps;
          w_nextLoop   = loop;
          w_nextRstn   = 1'b0;
          w_nextStim   = '0;
          w_nextIdx    = '0;
          w_nextRstCnt = RCW'(RST_CYCLES - 1);
          w_clearErr   = 1'b1;
        end
      end

      S_RST: begin
        if (r_rstCnt == '0) begin
          w_nextRstn = 1'b1;
          if (r_numSteps == '0) begin
            w_nextState = S_DONE;
            w_nextStim  = '0;
          end else begin
            w_nextState = S_RUN;
            w_nextStim  = w_loadValue;
            w_nextIdx   = '0;
            w_nextHold  = w_loadHold;
          end
        end else begin
          w_nextRstCnt = r_rstCnt - 1'b1;
        end
      end

      S_RUN: begin
        if (r_holdCnt == CW'(1)) begin
          w_stepEnd = 1'b1;
          if (w_isLast && !r_loop) begin
            w_nextState = S_DONE;
          end else begin
            w_nextIdx  = w_wrapIdx;
            w_nextStim = w_loadValue;
            w_nextHold = w_loadHold;
          end
        end else begin
          w_nextHold = r_holdCnt - 1'b1;
        end
      end

      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // State and output registers. Reset holds the DUT in reset (dut_resetn low)
  // until the first sequence starts.
  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_stim     <= '0;
      r_rstn     <= 1'b0;
      r_stepIdx  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_holdCnt  <= '0;
      r_rstCnt   <= '0;
      r_numSteps <= '0;
      r_loop     <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_stim     <= w_nextStim;
      r_rstn     <= w_nextRstn;
      r_stepIdx  <= w_nextIdx;
      r_busy     <= (w_nextState == S_RST) || (w_nextState == S_RUN);
      r_done     <= (w_nextState == S_DONE);
      r_holdCnt  <= w_nextHold;
      r_rstCnt   <= w_nextRstCnt;
      r_numSteps <= w_nextNum;
      r_loop     <= w_nextLoop;
    end
  end

`ifdef STIM_CHECK_EN
  logic [W-1:0] r_expectMem [DEPTH];
  logic         r_mismatch;
  logic [7:0]   r_errCount;

  // Expected responses live alongside the value/hold table and follow the
  // same write lockout.
  always_ff @(posedge CLOCK_50) begin
    if (w_tableWrite) begin
      r_expectMem[wr_addr] <= wr_expect;
    end
  end

  // Response checker. The DUT is sampled on the last cycle of each step so it
  // has had the whole hold time to settle; the result shows up on the edge
  // that ends the step.
  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      r_mismatch <= 1'b0;
      r_errCount <= '0;
    end else begin
      r_mismatch <= 1'b0;
      if (w_clearErr) begin
        r_errCount <= '0;
      end else if (w_stepEnd && (dut_resp != r_expectMem[r_stepIdx])) begin
        r_mismatch <= 1'b1;
        if (r_errCount != 8'hFF) begin
          r_errCount <= r_errCount + 8'd1;
        end
      end
    end
  end

  assign mismatch  = r_mismatch;
  assign err_count = r_errCount;
`else
  // Checking is compiled out; the response inputs are deliberately ignored.
  logic w_unusedCheck;
  assign w_unusedCheck = ^{wr_expect, dut_resp, w_clearErr, w_stepEnd};

  assign mismatch  = 1'b0;
  assign err_count = 8'd0;
`endif

  assign stim       = r_stim;
  assign dut_resetn = r_rstn;
  assign step_idx   = r_stepIdx;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_stim_sequencer.sv
// -----------------------------------------------------------------------------
// tb_stim_sequencer
//
// Purpose:
//   Self-checking bench for stim_sequencer. A bench-side model of the table
//   expands each sequence into the expected per-cycle output trace, queues it,
//   and the trace is popped and compared every cycle while the DUT runs.
//   Compile with STIM_CHECK_EN defined to exercise the response checker.
// -----------------------------------------------------------------------------
module tb_stim_sequencer;

  localparam int W          = 10;
  localparam int DEPTH      = 8;
  localparam int CW         = 16;
  localparam int RST_CYCLES = 1;
  localparam int AW         = $clog2(DEPTH);

`ifdef STIM_CHECK_EN
  localparam bit CHECK_ON = 1'b1;
`else
  localparam bit CHECK_ON = 1'b0;
`endif

  logic           CLOCK_50 = 1'b0;
  logic           Reset;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [W-1:0]   wr_value;
  logic [CW-1:0]  wr_hold;
  logic [W-1:0]   wr_expect;
  logic [AW:0]    num_steps;
  logic           loop;
  logic           start;
  logic [W-1:0]   dut_resp;
  logic [W-1:0]   stim;
  logic           dut_resetn;
  logic [AW-1:0]  step_idx;
  logic           busy;
  logic           done;
  logic           mismatch;
  logic [7:0]     err_count;
  logic           forceBad;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [W-1:0]  stim;
    logic          rstn;
    logic          busy;
    logic          done;
    logic [AW-1:0] idx;
    logic          idxCare;
    logic          mm;
    logic [7:0]    err;
  } exp_t;

  exp_t scoreQ[$];

  logic [W-1:0]  mValue  [DEPTH];
  logic [CW-1:0] mHold   [DEPTH];
  logic [W-1:0]  mExpect [DEPTH];

  // Free-running 100 MHz-style clock.
  always #5 CLOCK_50 = ~CLOCK_50;

  // The DUT response loops back the stimulus, optionally inverted to force
  // mismatches on every step.
  assign dut_resp = forceBad ? ~stim : stim;

  stim_sequencer #(
    .W(W), .DEPTH(DEPTH), .CW(CW), .RST_CYCLES(RST_CYCLES)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .Reset     (Reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_value  (wr_value),
    .wr_hold   (wr_hold),
    .wr_expect (wr_expect),
    .num_steps (num_steps),
    .loop      (loop),
    .start     (start),
    .dut_resp  (dut_resp),
    .stim      (stim),
    .dut_resetn(dut_resetn),
    .step_idx  (step_idx),
    .busy      (busy),
    .done      (done),
    .mismatch  (mismatch),
    .err_count (err_count)
  );

  // Write one table entry while the sequencer is idle and mirror it in the
  // bench model.
  task automatic writeEntry(input int addr, input logic [W-1:0] val,
                            input logic [CW-1:0] hold, input logic [W-1:0] expv);
    @(negedge CLOCK_50);
    wr_en     = 1'b1;
    wr_addr   = AW'(addr);
    wr_value  = val;
    wr_hold   = hold;
    wr_expect = expv;
    @(negedge CLOCK_50);
    wr_en = 1'b0;
    mValue[addr]  = val;
    mHold[addr]   = hold;
    mExpect[addr] = expv;
  endtask

  // Expand a sequence into its expected output trace, one entry per cycle
  // starting with the cycle after the start edge, capped at 'total' cycles.
  task automatic buildExpect(input int nSteps, input bit loopMode,
                             input int total, input bit bad);
    int eff;
    int k;
    int cnt;
    int h;
    int err;
    bit pend;
    exp_t e;
    logic [W-1:0] resp;
    eff  = (nSteps > DEPTH) ? DEPTH : nSteps;
    cnt  = 0;
    err  = 0;
    pend = 1'b0;
    for (int r = 0; r < RST_CYCLES && cnt < total; r++) begin
      e = '0;
      e.busy = 1'b1;
      scoreQ.push_back(e);
      cnt++;
    end
    if (eff == 0) begin
      while (cnt < total) begin
        e = '0;
        e.rstn = 1'b1;
        e.done = 1'b1;
        scoreQ.push_back(e);
        cnt++;
      end
    end else begin
      k = 0;
      while (cnt < total) begin
        h = (mHold[k] == '0) ? 1 : int'(mHold[k]);
        for (int c = 0; c < h && cnt < total; c++) begin
          e = '0;
          e.stim    = mValue[k];
          e.rstn    = 1'b1;
          e.busy    = 1'b1;
          e.idx     = AW'(k);
          e.idxCare = 1'b1;
          e.mm      = pend;
          e.err     = 8'(err);
          scoreQ.push_back(e);
          cnt++;
          pend = 1'b0;
          if (c == h - 1) begin
            resp = bad ? ~mValue[k] : mValue[k];
            if (CHECK_ON && (resp != mExpect[k])) begin
              pend = 1'b1;
              if (err < 255) err++;
            end
          end
        end
        if (k == eff - 1) begin
          if (!loopMode) break;
          k = 0;
        end else begin
          k++;
        end
      end
      while (cnt < total) begin
        e = '0;
        e.stim    = mValue[k];
        e.rstn    = 1'b1;
        e.done    = 1'b1;
        e.idx     = AW'(k);
        e.idxCare = 1'b1;
        e.mm      = pend;
        e.err     = 8'(err);
        scoreQ.push_back(e);
        cnt++;
        pend = 1'b0;
      end
    end
  endtask

  // Pulse start and compare the DUT against every queued cycle. At cycle
  // index pokeCycle (if non-negative) a table write to entry 1 and a second
  // start are driven while busy; both must be ignored.
  task automatic runSequence(input string name, input int pokeCycle);
    int n;
    exp_t e;
    exp_t obs;
    n = scoreQ.size();
    @(negedge CLOCK_50);
    start = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge CLOCK_50);
      start = 1'b0;
      wr_en = 1'b0;
      e = scoreQ.pop_front();
      obs.stim    = stim;
      obs.rstn    = dut_resetn;
      obs.busy    = busy;
      obs.done    = done;
      obs.idx     = e.idxCare ? step_idx : '0;
      obs.idxCare = e.idxCare;
      obs.mm      = mismatch;
      obs.err     = err_count;
      checks++;
      if (obs !== e) begin
        failures++;
        $display("[TB] FAIL %s cycle %0d: got stim=%h rstn=%b busy=%b done=%b idx=%0d mm=%b err=%0d, want stim=%h rstn=%b busy=%b done=%b idx=%0d mm=%b err=%0d",
                 name, i, obs.stim, obs.rstn, obs.busy, obs.done, obs.idx, obs.mm, obs.err,
                 e.stim, e.rstn, e.busy, e.done, e.idx, e.mm, e.err);
      end
      if (i == pokeCycle) begin
        wr_en     = 1'b1;
        wr_addr   = AW'(1);
        wr_value  = 10'h3FF;
        wr_hold   = 16'd9;
        wr_expect = 10'h3FF;
        start     = 1'b1;
      end
    end
    start = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic pulseReset();
    @(negedge CLOCK_50);
    Reset = 1'b1;
    @(negedge CLOCK_50);
    Reset = 1'b0;
  endtask

  task automatic loadDemoTable();
    writeEntry(0, 10'h200, 16'd28, 10'h200);
    writeEntry(1, 10'h355, 16'd25, 10'h355);
    writeEntry(2, 10'h2AA, 16'd25, 10'h2AA);
  endtask

  // Reset values, and the DUT held in reset while idle.
  task automatic test_reset();
    #2 Reset = 1'b1;
    #1;
    checks++;
    if ({stim, dut_resetn, step_idx, busy, done, mismatch, err_count} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_values: got stim=%h rstn=%b idx=%0d busy=%b done=%b mm=%b err=%0d, want all zero",
               stim, dut_resetn, step_idx, busy, done, mismatch, err_count);
    end
    @(negedge CLOCK_50);
    Reset = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    checks++;
    if ({dut_resetn, busy, done} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL idle_holds_reset: got rstn=%b busy=%b done=%b, want 0 0 0",
               dut_resetn, busy, done);
    end
  endtask

  task automatic test_one_shot();
    loadDemoTable();
    num_steps = 4'd3;
    loop      = 1'b0;
    buildExpect(3, 1'b0, RST_CYCLES + 78 + 5, 1'b0);
    runSequence("one_shot", -1);
  endtask

  task automatic test_loop();
    num_steps = 4'd3;
    loop      = 1'b1;
    buildExpect(3, 1'b1, RST_CYCLES + 78 * 3 + 4, 1'b0);
    runSequence("loop", -1);
    pulseReset();
    loop = 1'b0;
  endtask

  task automatic test_zero_steps();
    int tot;
    num_steps = 4'd0;
    buildExpect(0, 1'b0, RST_CYCLES + 4, 1'b0);
    runSequence("zero_steps", -1);
    for (int a = 3; a < DEPTH; a++) begin
      writeEntry(a, W'(10'h040 + a), CW'(a % 3), W'(10'h040 + a));
    end
    tot = RST_CYCLES;
    for (int a = 0; a < DEPTH; a++) begin
      tot += (mHold[a] == '0) ? 1 : int'(mHold[a]);
    end
    num_steps = 4'd12;
    buildExpect(12, 1'b0, tot + 3, 1'b0);
    runSequence("clamp_steps", -1);
  endtask

  task automatic test_back_to_back();
    writeEntry(0, 10'h0F0, 16'd6, 10'h0F0);
    writeEntry(1, 10'h155, 16'd0, 10'h155);
    writeEntry(2, 10'h0AB, 16'd3, 10'h0AB);
    num_steps = 4'd3;
    loop      = 1'b0;
    buildExpect(3, 1'b0, RST_CYCLES + 6 + 1 + 3 + 3, 1'b0);
    runSequence("busy_write", 2);
    buildExpect(3, 1'b0, RST_CYCLES + 6 + 1 + 3 + 3, 1'b0);
    runSequence("replay_after_busy_write", -1);
  endtask

  task automatic test_reset_mid_run();
    loadDemoTable();
    num_steps = 4'd3;
    loop      = 1'b0;
    buildExpect(3, 1'b0, RST_CYCLES + 28 + 5, 1'b0);
    runSequence("pre_reset", -1);
    #2 Reset = 1'b1;
    #1;
    checks++;
    if ({stim, dut_resetn, busy, done} !== {10'h000, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL async_reset: got stim=%h rstn=%b busy=%b done=%b, want 000 0 0 0",
               stim, dut_resetn, busy, done);
    end
    @(negedge CLOCK_50);
    Reset = 1'b0;
    buildExpect(3, 1'b0, RST_CYCLES + 78 + 3, 1'b0);
    runSequence("replay_after_reset", -1);
  endtask

  task automatic test_check();
    logic [7:0] expErr;
    writeEntry(0, 10'h200, 16'd28, 10'h200);
    writeEntry(1, 10'h355, 16'd25, 10'h000);
    writeEntry(2, 10'h2AA, 16'd25, 10'h2AA);
    num_steps = 4'd3;
    loop      = 1'b0;
    buildExpect(3, 1'b0, RST_CYCLES + 78 + 3, 1'b0);
    runSequence("check_one", -1);
    expErr = CHECK_ON ? 8'd1 : 8'd0;
    checks++;
    if (err_count !== expErr) begin
      failures++;
      $display("[TB] FAIL err_count_one: got %0d, want %0d", err_count, expErr);
    end
    writeEntry(0, 10'h011, 16'd0, 10'h011);
    writeEntry(1, 10'h022, 16'd0, 10'h022);
    num_steps = 4'd2;
    loop      = 1'b1;
    forceBad  = 1'b1;
    buildExpect(2, 1'b1, RST_CYCLES + 310, 1'b1);
    runSequence("check_saturate", -1);
    expErr = CHECK_ON ? 8'd255 : 8'd0;
    checks++;
    if (err_count !== expErr) begin
      failures++;
      $display("[TB] FAIL err_count_saturate: got %0d, want %0d", err_count, expErr);
    end
    pulseReset();
    forceBad = 1'b0;
    loop     = 1'b0;
  endtask

  initial begin
    Reset     = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_value  = '0;
    wr_hold   = '0;
    wr_expect = '0;
    num_steps = '0;
    loop      = 1'b0;
    start     = 1'b0;
    forceBad  = 1'b0;

    test_reset();
    test_one_shot();
    test_loop();
    test_zero_steps();
    test_back_to_back();
    test_reset_mid_run();
    test_check();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
